mac_param: RTL and testbench

Parametrised, pipelined multiply-accumulate unit for the MNIST CNN datapath. It is the successor to the single-shot multiplier. It accepts a stream of `TAPS` operand pairs under a valid/ready handshake and sums their products into a wide accumulator. It then presents one result per window under an output valid/ready handshake. Convolution and fully-connected stages use it as the per-neuron dot-product engine.

---
 rtl/mac_param.sv | 233 +++++++++++++++++++++++
 tb/tb_mac_param.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_param.sv
// -----------------------------------------------------------------------------
// mac_param
//
// Pipelined multiply-accumulate engine used as the per-neuron dot-product
// unit of the MNIST CNN datapath. A window is opened with `start`. TAPS
// operand pairs are then accepted under a valid/ready handshake. Each pair
// is multiplied into a registered full-width product, and the product is
// added into a wide accumulator on the following edge. The window sum is
// then offered on an output valid/ready handshake.
//
// Parameters
//   WIDTH      operand width of A and B
//   TAPS       operand pairs per window (>= 1)
//   ACC_WIDTH  accumulator / result width (>= 2*WIDTH)
//   SIGNED     1: two's complement operands, 0: unsigned operands
//
// Optional feature (compile-time macro)
//   MAC_SAT_EN defined   : an overflowing addition clamps the accumulator to
//                          the extreme of its range.
//   MAC_SAT_EN undefined : additions wrap modulo 2^ACC_WIDTH.
//   In both builds `ovf` is set and stays set for the rest of the window.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   opens a new window (only looked at in IDLE)
//   in_valid     in   A/B hold a valid pair
//   A, B         in   multiplicand / multiplier
//   in_ready     out  a pair is accepted this cycle (ACCUM only)
//   out_valid    out  result/ovf are valid (OUT only)
//   out_ready    in   downstream takes result
//   result       out  window sum (the accumulator)
//   busy         out  state is not IDLE
//   ovf          out  window overflowed ACC_WIDTH
//   o_dbg_state  out  current FSM state (IDLE=0, ACCUM=1, DRAIN=2, OUT=3)
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. Valid never depends on ready. While out_valid is high,
// result and ovf do not change until the transfer takes place.
// -----------------------------------------------------------------------------
module mac_param #(
    parameter int WIDTH     = 8,
    parameter int TAPS      = 9,
    parameter int ACC_WIDTH = 20,
    parameter int SIGNED    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 busy,
    output logic                 ovf,
    output logic [1:0]           o_dbg_state
);

    localparam int PW    = 2 * WIDTH;
    // The counter must be able to hold the value TAPS.
    localparam int CNT_W = (TAPS < 2) ? 1 : $clog2(TAPS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [CNT_W-1:0]     r_cnt;
    logic [PW-1:0]        r_prod;
    logic                 r_prod_valid;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_last_accept;
    logic                 w_open;

    logic [PW-1:0]        w_prod;
    logic [ACC_WIDTH-1:0] w_addend;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_add_ovf;
    logic [ACC_WIDTH-1:0] w_clamp;
    logic [ACC_WIDTH-1:0] w_acc_next;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_in_ready = 1'b1;
                if (w_last_accept) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last product is still in flight; it lands this edge.
                w_next_state = S_OUT;
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_accept      = in_valid & w_in_ready;
    assign w_last_accept = w_accept && (r_cnt == CNT_W'(TAPS - 1));
    assign w_open        = (r_state == S_IDLE) && start;

    // ------------------------------------------------------------------
    // Multiplier: full 2*WIDTH product, sign handling chosen by SIGNED.
    // Operands are widened before the multiply, so the low PW bits of the
    // product are exact in both modes.
    // ------------------------------------------------------------------
    always_comb begin
        if (SIGNED != 0) begin
            w_prod = PW'($signed(A)) * PW'($signed(B));
        end else begin
            w_prod = PW'(A) * PW'(B);
        end
    end

    // ------------------------------------------------------------------
    // Accumulator adder with overflow detection
    // ------------------------------------------------------------------
    always_comb begin
        if (SIGNED != 0) begin
            w_addend = ACC_WIDTH'($signed(r_prod));
        end else begin
            w_addend = ACC_WIDTH'(r_prod);
        end
    end

    assign w_sum = {1'b0, r_acc} + {1'b0, w_addend};

    always_comb begin
        w_add_ovf = 1'b0;
        w_clamp   = '0;
        if (SIGNED != 0) begin
            // Signed overflow: both operands share a sign that the sum lost.
            w_add_ovf = (r_acc[ACC_WIDTH-1] == w_addend[ACC_WIDTH-1]) &&
                        (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
            // The operands' common sign tells which extreme was crossed.
            w_clamp   = r_acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            w_add_ovf = w_sum[ACC_WIDTH];
            w_clamp   = {ACC_WIDTH{1'b1}};
        end
    end

`ifdef MAC_SAT_EN
    assign w_acc_next = w_add_ovf ? w_clamp : w_sum[ACC_WIDTH-1:0];
`else
    assign w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_prod       <= '0;
            r_prod_valid <= 1'b0;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
        end else if (w_open) begin
            r_cnt        <= '0;
            r_prod       <= '0;
            r_prod_valid <= 1'b0;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_prod <= w_prod;
                r_cnt  <= r_cnt + CNT_W'(1);
            end
            // Product-valid follows acceptance by one edge; it is what lets
            // input gaps pass without disturbing the accumulator.
            r_prod_valid <= w_accept;
            if (r_prod_valid) begin
                r_acc <= w_acc_next;
                if (w_add_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign result      = r_acc;
    assign ovf         = r_ovf;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mac_param.sv
module tb_mac_param;

  localparam int ND = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------------------------------------------------------- DUT signals
  logic       start     [ND];
  logic       in_valid  [ND];
  logic       out_ready [ND];
  logic [7:0] a         [ND];
  logic [7:0] b         [ND];
  logic       in_ready  [ND];
  logic       out_valid [ND];
  logic       busy      [ND];
  logic       ovf       [ND];
  logic [1:0] dbg       [ND];
  logic [19:0] res0, res1, res2;
  logic [15:0] res3;

  // per-instance configuration: default, unsigned, TAPS=4, ACC_WIDTH=16
  int taps_of [ND] = '{9, 9, 4, 9};
  int sgn_of  [ND] = '{1, 0, 1, 1};
  int accw_of [ND] = '{20, 20, 20, 16};

  mac_param u_def (
    .clk(clk), .reset(reset_n), .start(start[0]), .in_valid(in_valid[0]),
    .A(a[0]), .B(b[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .result(res0), .busy(busy[0]), .ovf(ovf[0]),
    .o_dbg_state(dbg[0]));

  mac_param #(.SIGNED(0)) u_uns (
    .clk(clk), .reset(reset_n), .start(start[1]), .in_valid(in_valid[1]),
    .A(a[1]), .B(b[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .result(res1), .busy(busy[1]), .ovf(ovf[1]),
    .o_dbg_state(dbg[1]));

  mac_param #(.TAPS(4)) u_t4 (
    .clk(clk), .reset(reset_n), .start(start[2]), .in_valid(in_valid[2]),
    .A(a[2]), .B(b[2]), .in_ready(in_ready[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .result(res2), .busy(busy[2]), .ovf(ovf[2]),
    .o_dbg_state(dbg[2]));

  mac_param #(.ACC_WIDTH(16)) u_a16 (
    .clk(clk), .reset(reset_n), .start(start[3]), .in_valid(in_valid[3]),
    .A(a[3]), .B(b[3]), .in_ready(in_ready[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .result(res3), .busy(busy[3]), .ovf(ovf[3]),
    .o_dbg_state(dbg[3]));

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint get_res(input int d);
    case (d)
      0: return longint'(res0);
      1: return longint'(res1);
      2: return longint'(res2);
      default: return longint'(res3);
    endcase
  endfunction

  // ---------------------------------------------------------------- reference model
  // Sums the products as plain integers, one addition at a time, and applies
  // the range rule of the configured accumulator after every addition.
  function automatic void model(input int d, input logic [8:0][7:0] av,
                                input logic [8:0][7:0] bv,
                                output longint r, output bit o);
    longint m, hi, lo, acc, x, y, s;
    m = 64'sd1 <<< accw_of[d];
    if (sgn_of[d] != 0) begin hi = m / 2 - 1; lo = -(m / 2); end
    else begin hi = m - 1; lo = 0; end
    acc = 0;
    o = 1'b0;
    for (int i = 0; i < taps_of[d]; i++) begin
      if (sgn_of[d] != 0) begin
        x = longint'($signed(av[i]));
        y = longint'($signed(bv[i]));
      end else begin
        x = longint'(av[i]);
        y = longint'(bv[i]);
      end
      s = acc + x * y;
      if (s > hi || s < lo) begin
        o = 1'b1;
`ifdef MAC_SAT_EN
        s = (s > hi) ? hi : lo;
`else
        s = s % m;
        if (s < 0) s = s + m;
        if (s > hi) s = s - m;
`endif
      end
      acc = s;
    end
    r = acc & (m - 1);
  endfunction

  // ---------------------------------------------------------------- driver
  // Inputs change on the falling edge; outputs are sampled there as well.
  task automatic run_window(input int d, input logic [8:0][7:0] av,
                            input logic [8:0][7:0] bv, input int gap,
                            input int stall, input string tag);
    longint r_hold;
    logic   o_hold;
    logic [31:0] exp_r;
    logic        exp_o;
    exp_r = exp_q.pop_front();
    exp_o = exp_r[31];
    exp_r[31] = 1'b0;

    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check({tag, " in_ready after start"}, longint'(in_ready[d]), 1);
    check({tag, " busy after start"}, longint'(busy[d]), 1);

    for (int i = 0; i < taps_of[d]; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid[d] = 1'b0;
          a[d] = 8'($urandom);
          b[d] = 8'($urandom);
          @(negedge clk);
        end
      end
      in_valid[d] = 1'b1;
      a[d] = av[i];
      b[d] = bv[i];
      @(negedge clk);
    end
    in_valid[d] = 1'b0;

    // one cycle after the last accept: DRAIN
    check({tag, " in_ready in drain"}, longint'(in_ready[d]), 0);
    check({tag, " out_valid in drain"}, longint'(out_valid[d]), 0);
    @(negedge clk);
    check({tag, " out_valid latency"}, longint'(out_valid[d]), 1);
    check({tag, " result"}, get_res(d), longint'(exp_r));
    check({tag, " ovf"}, longint'(ovf[d]), longint'(exp_o));
    r_hold = get_res(d);
    o_hold = ovf[d];

    for (int s = 0; s < stall; s++) begin
      start[d]    = 1'($urandom_range(0, 1));
      in_valid[d] = 1'($urandom_range(0, 1));
      a[d] = 8'($urandom);
      b[d] = 8'($urandom);
      @(negedge clk);
      check({tag, " stall result stable"}, get_res(d), r_hold);
      check({tag, " stall ovf stable"}, longint'(ovf[d]), longint'(o_hold));
      check({tag, " stall in_ready"}, longint'(in_ready[d]), 0);
      check({tag, " stall out_valid"}, longint'(out_valid[d]), 1);
    end
    start[d]     = 1'b0;
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check({tag, " out_valid after take"}, longint'(out_valid[d]), 0);
    check({tag, " busy after take"}, longint'(busy[d]), 0);
  endtask

  // push expected {ovf, result} for the next window of instance d
  task automatic push_exp(input int d, input longint er, input bit eo);
    longint m;
    m = 64'sd1 <<< accw_of[d];
    exp_q.push_back({eo, 31'(er & (m - 1))});
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct packed {
    logic [1:0]       d;
    logic [8:0][7:0]  a;
    logic [8:0][7:0]  b;
    logic [1:0]       gap;
    logic [2:0]       stall;
    logic signed [31:0] er;
    logic             eo;
  } vec_t;

  function automatic vec_t mk(input int d, input int ca, input int cb,
                              input int er, input bit eo, input int stall);
    vec_t v;
    v = '0;
    v.d = 2'(d);
    for (int i = 0; i < 9; i++) begin
      v.a[i] = 8'(ca);
      v.b[i] = 8'(cb);
    end
    v.er = er;
    v.eo = eo;
    v.stall = 3'(stall);
    return v;
  endfunction

  vec_t vtab[8];

  // ---------------------------------------------------------------- main
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [8:0][7:0] ra, rb;
    longint mr;
    bit     mo;
    int     d;

    vtab[0] = mk(0, -128, -128, 147456, 1'b0, 0);
    vtab[1] = mk(1, 255, 255, 585225, 1'b0, 1);
    vtab[2] = mk(2, 0, 0, 19, 1'b0, 0);
    vtab[2].a[0] = 8'd3;          vtab[2].b[0] = 8'hFC;   // (3,-4)
    vtab[2].a[1] = 8'hFB;         vtab[2].b[1] = 8'hFA;   // (-5,-6)
    vtab[2].a[2] = 8'd7;          vtab[2].b[2] = 8'd0;    // (7,0)
    vtab[2].a[3] = 8'd1;          vtab[2].b[3] = 8'd1;    // (1,1)
    vtab[2].gap = 2'd2;
`ifdef MAC_SAT_EN
    vtab[3] = mk(3, 127, 127, 32767, 1'b1, 0);
    vtab[6] = mk(3, -128, 127, -32768, 1'b1, 2);
`else
    vtab[3] = mk(3, 127, 127, 14089, 1'b1, 0);
    vtab[6] = mk(3, -128, 127, -15232, 1'b1, 2);
`endif
    vtab[4] = mk(0, 127, -128, -146304, 1'b0, 5);   // back-pressure window
    vtab[5] = mk(1, 0, 200, 0, 1'b0, 0);
    vtab[7] = mk(2, -1, -1, 4, 1'b0, 1);

    for (int i = 0; i < ND; i++) begin
      start[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      a[i] = '0; b[i] = '0;
    end

    // reset state
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      check($sformatf("rst%0d in_ready", i), longint'(in_ready[i]), 0);
      check($sformatf("rst%0d out_valid", i), longint'(out_valid[i]), 0);
      check($sformatf("rst%0d busy", i), longint'(busy[i]), 0);
      check($sformatf("rst%0d ovf", i), longint'(ovf[i]), 0);
      check($sformatf("rst%0d result", i), get_res(i), 0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // table-driven windows
    for (int i = 0; i < 8; i++) begin
      d = int'(vtab[i].d);
      push_exp(d, longint'(vtab[i].er), vtab[i].eo);
      run_window(d, vtab[i].a, vtab[i].b, int'(vtab[i].gap),
                 int'(vtab[i].stall), $sformatf("vec%0d", i));
    end

    // reset in the middle of a window, after 4 of 9 accepts
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      a[0] = 8'd50;
      b[0] = 8'd60;
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    check("midrst in_ready", longint'(in_ready[0]), 0);
    check("midrst out_valid", longint'(out_valid[0]), 0);
    check("midrst busy", longint'(busy[0]), 0);
    check("midrst ovf", longint'(ovf[0]), 0);
    check("midrst result", get_res(0), 0);
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("midrst no out_valid", longint'(out_valid[0]), 0);
    reset_n = 1'b1;
    begin
      vec_t v;
      v = mk(0, 1, 2, 18, 1'b0, 0);
      push_exp(0, 18, 1'b0);
      run_window(0, v.a, v.b, 0, 0, "after_rst");
    end

    // randomized windows against the reference model
    for (int it = 0; it < 40; it++) begin
      d = $urandom_range(0, ND - 1);
      for (int i = 0; i < 9; i++) begin
        if (d == 3 && $urandom_range(0, 1) == 1) begin
          ra[i] = 8'($urandom_range(90, 127));
          rb[i] = 8'($urandom_range(90, 127));
        end else begin
          ra[i] = 8'($urandom);
          rb[i] = 8'($urandom);
        end
      end
      model(d, ra, rb, mr, mo);
      push_exp(d, mr, mo);
      run_window(d, ra, rb, $urandom_range(0, 2), $urandom_range(0, 3),
                 $sformatf("rnd%0d_d%0d", it, d));
    end

    check("expected queue drained", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
